// File: rtl/mux_sel_pipe.sv
// Pipelined channel selector: picks one WIDTH-bit slice of a flat channel bus
// per accepted request and returns it through a two-entry (output + skid) buffer.
module mux_sel_pipe #(
   parameter int               WIDTH      = 5,
   parameter int               NUM_CH     = 8,
   parameter int               CONST_CH   = 1,
   parameter logic [WIDTH-1:0] CONST_VAL  = WIDTH'(16),
   parameter int               DEFAULT_CH = 0,
   localparam int              SEL_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        selector,
   input  logic                    sel_hold,
   input  logic [NUM_CH*WIDTH-1:0] data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        data_out,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err
);

   localparam int               EXT_W     = SEL_W + 1;
   localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_CH);
   localparam logic [SEL_W-1:0] CONST_SEL = SEL_W'(CONST_CH);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             err;
   } result_t;

   state_t           state, state_nxt;
   result_t          out_q, skid_q, req;
   logic [SEL_W-1:0] last_sel;
   logic [EXT_W-1:0] sel_ext;
   logic             take_in, take_out;
   logic             load_out_req, load_out_skid, load_skid;

   // Handshake depends only on registered state, so no combinational path
   // runs from in_valid/out_ready back to in_ready.
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign take_in   = in_valid && in_ready;
   assign take_out  = out_valid && out_ready;

   assign data_out  = out_q.data;
   assign out_sel   = out_q.sel;
   assign sel_err   = out_q.err;

   // Widened by one bit so the range check stays meaningful when NUM_CH is a power of two.
   assign sel_ext   = {1'b0, selector};

   always_comb begin
      // NOTE: every output of a combinational block gets a default first;
      // a path that leaves one unassigned would infer a latch.
      req = '0;
      if (sel_hold) begin
         req.sel = last_sel;
      end else if (sel_ext < EXT_W'(NUM_CH)) begin
         req.sel = selector;
      end else begin
         req.sel = DEF_SEL;
         req.err = 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (req.sel == SEL_W'(i)) req.data = data_in[i*WIDTH +: WIDTH];
      end
      if (req.sel == CONST_SEL) req.data = CONST_VAL;
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!reset) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      load_out_req  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         EMPTY: begin
            if (take_in) begin
               state_nxt    = ONE;
               load_out_req = 1'b1;
            end
         end
         ONE: begin
            if (take_in && take_out) begin
               load_out_req = 1'b1;
            end else if (take_in) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end else if (take_out) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (take_out) begin
               state_nxt     = ONE;
               load_out_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q    <= '{data: '0, sel: DEF_SEL, err: 1'b0};
         skid_q   <= '0;
         last_sel <= DEF_SEL;
      end else begin
         if (load_out_req)       out_q <= req;
         else if (load_out_skid) out_q <= skid_q;
         if (load_skid)          skid_q <= req;
         if (take_in)            last_sel <= req.sel;
      end
   end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: default 8-channel instance plus a
// 6-channel instance for the out-of-range selector case.
module tb_mux_sel_pipe;

   localparam int W = 5;

   logic          clk;
   logic          reset;

   logic          in_valid, in_ready, sel_hold, out_valid, out_ready, sel_err;
   logic [2:0]    selector, out_sel;
   logic [8*W-1:0] data_in;
   logic [W-1:0]  data_out;

   logic          in_valid6, in_ready6, sel_hold6, out_valid6, out_ready6, sel_err6;
   logic [2:0]    selector6, out_sel6;
   logic [6*W-1:0] data_in6;
   logic [W-1:0]  data_out6;

   int check_cnt = 0;
   int pass_cnt  = 0;

   mux_sel_pipe u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .selector(selector), .sel_hold(sel_hold), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .out_sel(out_sel), .sel_err(sel_err)
   );

   mux_sel_pipe #(.NUM_CH(6)) u_dut6 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid6), .in_ready(in_ready6),
      .selector(selector6), .sel_hold(sel_hold6), .data_in(data_in6),
      .out_valid(out_valid6), .out_ready(out_ready6),
      .data_out(data_out6), .out_sel(out_sel6), .sel_err(sel_err6)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b0;
      in_valid = 0; sel_hold = 0; selector = 0; out_ready = 1;
      in_valid6 = 0; sel_hold6 = 0; selector6 = 0; out_ready6 = 1;
      data_in  = {5'd19, 5'd17, 5'd15, 5'd13, 5'd11, 5'd9, 5'd7, 5'd3};
      data_in6 = {5'd15, 5'd13, 5'd11, 5'd9, 5'd7, 5'd3};

      // reset state
      #2;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_data_out",  32'(data_out), 0);
      check("rst_out_sel",   32'(out_sel), 0);
      check("rst_sel_err",   32'(sel_err), 0);
      check("rst_in_ready",  32'(in_ready), 1);
      tick(); tick();
      reset = 1'b1;

      // back-to-back selectors 0..3
      in_valid = 1; selector = 0; tick();
      check("b2b0_valid", 32'(out_valid), 1);
      check("b2b0_data", 32'(data_out), 3);
      check("b2b0_sel",  32'(out_sel), 0);
      selector = 1; tick();
      check("b2b1_const", 32'(data_out), 16);
      check("b2b1_sel",   32'(out_sel), 1);
      selector = 2; tick();
      check("b2b2_data", 32'(data_out), 9);
      selector = 3; tick();
      check("b2b3_data", 32'(data_out), 11);
      check("b2b3_sel",  32'(out_sel), 3);
      check("b2b3_err",  32'(sel_err), 0);

      // hold reuses last effective selector
      sel_hold = 1; selector = 5; tick();
      check("hold1_sel",  32'(out_sel), 3);
      check("hold1_data", 32'(data_out), 11);
      tick();
      check("hold2_sel",  32'(out_sel), 3);
      in_valid = 0; sel_hold = 0; tick();
      check("drain_valid", 32'(out_valid), 0);

      // hold right after reset -> default channel
      reset = 1'b0; #2;
      check("rst2_valid", 32'(out_valid), 0);
      reset = 1'b1;
      in_valid = 1; sel_hold = 1; selector = 5; tick();
      check("hold_rst_sel",  32'(out_sel), 0);
      check("hold_rst_data", 32'(data_out), 3);
      in_valid = 0; sel_hold = 0; tick();

      // backpressure: fill output + skid
      out_ready = 0; in_valid = 1; selector = 2; tick();
      check("bp1_ready", 32'(in_ready), 1);
      check("bp1_data",  32'(data_out), 9);
      selector = 3; tick();
      check("bp2_ready", 32'(in_ready), 0);
      check("bp2_data",  32'(data_out), 9);
      selector = 4; tick();
      check("bp3_ready", 32'(in_ready), 0);
      check("bp3_sel",   32'(out_sel), 2);
      data_in[2*W +: W] = 5'd21; tick();
      check("stall_data_held", 32'(data_out), 9);
      out_ready = 1; tick();
      check("pop1_data",  32'(data_out), 11);
      check("pop1_sel",   32'(out_sel), 3);
      check("pop1_ready", 32'(in_ready), 1);
      tick();
      check("pop2_data", 32'(data_out), 13);
      check("pop2_sel",  32'(out_sel), 4);
      in_valid = 0; tick();
      check("pop3_valid", 32'(out_valid), 0);
      data_in[2*W +: W] = 5'd9;

      // reset while holding two results
      out_ready = 0; in_valid = 1; selector = 5; tick();
      selector = 6; tick();
      in_valid = 0;
      check("two_ready", 32'(in_ready), 0);
      #2 reset = 1'b0; #1;
      check("rst_two_valid", 32'(out_valid), 0);
      check("rst_two_data",  32'(data_out), 0);
      check("rst_two_ready", 32'(in_ready), 1);
      tick();
      reset = 1'b1;
      out_ready = 1; in_valid = 1; selector = 7; tick();
      check("post_rst_data",  32'(data_out), 19);
      check("post_rst_sel",   32'(out_sel), 7);
      check("post_rst_valid", 32'(out_valid), 1);
      in_valid = 0; tick();
      check("post_rst_drain", 32'(out_valid), 0);

      // 6-channel instance: out-of-range selector
      in_valid6 = 1; selector6 = 7; tick();
      check("oor_data", 32'(data_out6), 3);
      check("oor_sel",  32'(out_sel6), 0);
      check("oor_err",  32'(sel_err6), 1);
      selector6 = 2; tick();
      check("inr_data", 32'(data_out6), 9);
      check("inr_sel",  32'(out_sel6), 2);
      check("inr_err",  32'(sel_err6), 0);
      in_valid6 = 0; tick();
      check("ch6_drain", 32'(out_valid6), 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
